pcont_instsel: RTL and testbench

Instruction-register sequencer for the fetch (SF) stage. It generates the one-hot `CLMI_SELINST_S_P` select (zero/load/hold) and `CLMI_RHOLD` that drive the SF-stage instruction register and ISA-mode latch. It does this from the I-cache valid handshake, pipeline stall, flush and debug-halt requests. It sits in `pcont` beside the instruction register, between the I-cache interface and the pipeline control.

---
 rtl/pcont_instsel.sv | 234 +++++++++++++++++++++++
 tb/tb_pcont_instsel.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pcont_instsel.sv
// ---------------------------------------------------------------------------
// pcont_instsel -- SF-stage instruction-register sequencer.
//
// Generates the one-hot instruction-register select (ZERO / LOAD / HOLD) and
// the matching hold for the ISA-mode latch. Inputs are the I-cache valid
// handshake, downstream stall, SF-stage flush and debug halt. The select is
// combinational so that a valid word is loaded at the same SYSCLK edge that
// sees ICACHE_VALID_I.
//
// Ports:
//   SYSCLK            in   clock, rising edge
//   RESET_D1_R        in   synchronous active-high reset
//   ICACHE_VALID_I    in   I-cache word valid (held until LOAD selected)
//   PIPE_STALL_P      in   downstream stall, SF register must hold
//   FLUSH_P           in   exception/branch kill of the SF stage
//   DBG_HALT_P        in   debug halt request (level)
//   CLMI_SELINST_S_P  out  one-hot select [HOLD, LOAD, ZERO]
//   CLMI_RHOLD        out  hold for ISA-mode latch / downstream registers
//   FETCH_REQ_O       out  fetch request to the I-cache
//   MISS_TIMEOUT_O    out  one-cycle pulse when miss wait reaches MISS_LIMIT
//   PERF_STALL_CNT_O  out  count of non-LOAD cycles (0 when feature absent)
//
// Optional feature: define PCONT_INSTSEL_PERF_EN to build the 32-bit
// non-LOAD cycle counter; otherwise PERF_STALL_CNT_O is tied to zero.
// ---------------------------------------------------------------------------
module pcont_instsel #(
  parameter int MISS_LIMIT = 255,
  parameter int MISS_CNT_W = 8
) (
  input  logic        SYSCLK,
  input  logic        RESET_D1_R,
  input  logic        ICACHE_VALID_I,
  input  logic        PIPE_STALL_P,
  input  logic        FLUSH_P,
  input  logic        DBG_HALT_P,
  output logic [2:0]  CLMI_SELINST_S_P,
  output logic        CLMI_RHOLD,
  output logic        FETCH_REQ_O,
  output logic        MISS_TIMEOUT_O,
  output logic [31:0] PERF_STALL_CNT_O
);

  // Bit positions within the one-hot select.
  localparam int CLMI_SEL_INST_ZERO_POS = 0;
  localparam int CLMI_SEL_INST_LOAD_POS = 1;
  localparam int CLMI_SEL_INST_HOLD_POS = 2;
  localparam int CLMI_SEL_INST_HI       = 2;

  localparam logic [CLMI_SEL_INST_HI:0] SEL_ZERO = 3'b001;
  localparam logic [CLMI_SEL_INST_HI:0] SEL_LOAD = 3'b010;
  localparam logic [CLMI_SEL_INST_HI:0] SEL_HOLD = 3'b100;

  localparam logic [MISS_CNT_W-1:0] LIMIT_C = MISS_CNT_W'(MISS_LIMIT);
  localparam logic [MISS_CNT_W-1:0] ONE_C   = MISS_CNT_W'(1);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_RUN   = 3'd1,
    ST_MISS  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  state_e                        state_q, state_d;
  logic [MISS_CNT_W-1:0]         cnt_q, cnt_d;
  logic [CLMI_SEL_INST_HI:0]     sel_d;
  logic                          cnt_inc;
  logic                          cnt_sat;

  // Selection and next state under the RUN priority order; reused by HALT
  // on the cycle the halt request drops.
  logic [CLMI_SEL_INST_HI:0]     run_sel;
  state_e                        run_next;
  logic                          run_miss;

  assign cnt_sat = (cnt_q == LIMIT_C);

  always_comb begin
    run_sel  = SEL_ZERO;
    run_next = ST_RUN;
    run_miss = 1'b0;
    if (FLUSH_P) begin
      run_sel  = SEL_ZERO;
      run_next = ST_FLUSH;
    end else if (DBG_HALT_P) begin
      run_sel  = SEL_HOLD;
      run_next = ST_HALT;
    end else if (PIPE_STALL_P) begin
      run_sel  = SEL_HOLD;
      run_next = ST_RUN;
    end else if (ICACHE_VALID_I) begin
      run_sel  = SEL_LOAD;
      run_next = ST_RUN;
    end else begin
      // No word available: issue a NOP bubble and start the miss wait.
      run_sel  = SEL_ZERO;
      run_next = ST_MISS;
      run_miss = 1'b1;
    end
  end

  always_comb begin
    sel_d   = SEL_ZERO;
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = 1'b0;

    if (RESET_D1_R) begin
      sel_d   = SEL_ZERO;
      state_d = ST_RST;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RST: begin
          // Post-release cycle: bubble while the first fetch is requested.
          sel_d   = SEL_ZERO;
          state_d = ST_RUN;
        end

        ST_RUN: begin
          sel_d   = run_sel;
          state_d = run_next;
          if (run_miss) begin
            cnt_d = '0;
          end
        end

        ST_MISS: begin
          if (FLUSH_P) begin
            sel_d   = SEL_ZERO;
            state_d = ST_FLUSH;
          end else if (DBG_HALT_P) begin
            sel_d   = SEL_HOLD;
            state_d = ST_HALT;
          end else if (PIPE_STALL_P) begin
            // A stalled miss still ages the wait counter.
            sel_d   = SEL_HOLD;
            state_d = ST_MISS;
            cnt_inc = 1'b1;
          end else if (ICACHE_VALID_I) begin
            sel_d   = SEL_LOAD;
            state_d = ST_RUN;
          end else begin
            sel_d   = SEL_ZERO;
            state_d = ST_MISS;
            cnt_inc = 1'b1;
          end
        end

        ST_FLUSH: begin
          sel_d   = SEL_ZERO;
          state_d = FLUSH_P ? ST_FLUSH : ST_RUN;
        end

        ST_HALT: begin
          if (FLUSH_P) begin
            sel_d   = SEL_ZERO;
            state_d = ST_FLUSH;
          end else if (DBG_HALT_P) begin
            sel_d   = SEL_HOLD;
            state_d = ST_HALT;
          end else begin
            // Halt released: select by RUN rules this cycle, resume in RUN.
            sel_d   = run_sel;
            state_d = ST_RUN;
          end
        end

        default: begin
          sel_d   = SEL_ZERO;
          state_d = ST_RST;
          cnt_d   = '0;
        end
      endcase

      // Saturating miss counter: frozen once MISS_LIMIT is reached.
      if (cnt_inc && !cnt_sat) begin
        cnt_d = cnt_q + ONE_C;
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CLMI_SELINST_S_P = sel_d;
  assign CLMI_RHOLD       = sel_d[CLMI_SEL_INST_HOLD_POS];

  // Request stays up through stalls; dropped only while halted or in reset.
  assign FETCH_REQ_O = !RESET_D1_R &&
                       ((state_q == ST_RST) || (state_q == ST_RUN) ||
                        (state_q == ST_MISS) || (state_q == ST_FLUSH));

  // Pulses on the cycle whose increment lands the counter on MISS_LIMIT;
  // a reset in that cycle suppresses it because cnt_inc is held low.
  assign MISS_TIMEOUT_O = cnt_inc && !cnt_sat && ((cnt_q + ONE_C) == LIMIT_C);

`ifdef PCONT_INSTSEL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      perf_q <= '0;
    end else if (!sel_d[CLMI_SEL_INST_LOAD_POS]) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign PERF_STALL_CNT_O = perf_q;
`else
  assign PERF_STALL_CNT_O = 32'h0;
`endif

`ifndef SYNTHESIS
  // Simulation guard: the select must never leave one-hot encoding.
  always_ff @(posedge SYSCLK) begin
    if (!RESET_D1_R && !$onehot(sel_d)) begin
      $display("ERROR pcont_instsel: select not one-hot (%b)", sel_d);
      $stop;
    end
  end
`endif

  // Position of the ZERO bit is implied by the encodings above.
  localparam int ZERO_POS_CHECK = CLMI_SEL_INST_ZERO_POS;

endmodule

// File: tb/tb_pcont_instsel.sv
module tb_pcont_instsel;

  localparam logic [2:0] S_ZERO = 3'b001;
  localparam logic [2:0] S_LOAD = 3'b010;
  localparam logic [2:0] S_HOLD = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        stall;
  logic        flush;
  logic        halt;
  logic [2:0]  sel;
  logic        rhold;
  logic        fetch;
  logic        tmo;
  logic [31:0] perf;
  logic [31:0] perf_before;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcont_instsel #(
    .MISS_LIMIT (4),
    .MISS_CNT_W (3)
  ) dut (
    .SYSCLK           (clk),
    .RESET_D1_R       (rst),
    .ICACHE_VALID_I   (valid),
    .PIPE_STALL_P     (stall),
    .FLUSH_P          (flush),
    .DBG_HALT_P       (halt),
    .CLMI_SELINST_S_P (sel),
    .CLMI_RHOLD       (rhold),
    .FETCH_REQ_O      (fetch),
    .MISS_TIMEOUT_O   (tmo),
    .PERF_STALL_CNT_O (perf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs mid-cycle,
  // then advance past the next rising edge.
  task automatic step(input string tag, input logic r, input logic v, input logic s,
                      input logic f, input logic h, input logic [2:0] esel,
                      input logic efetch, input logic eto);
    rst = r; valid = v; stall = s; flush = f; halt = h;
    #2;
    chk({tag, " sel"},   32'(sel),   32'(esel));
    chk({tag, " rhold"}, 32'(rhold), 32'(esel == S_HOLD));
    chk({tag, " fetch"}, 32'(fetch), 32'(efetch));
    chk({tag, " tmo"},   32'(tmo),   32'(eto));
    $display("%-8s rst=%b v=%b s=%b f=%b h=%b sel=%b rhold=%b fetch=%b tmo=%b perf=%0d",
             tag, r, v, s, f, h, sel, rhold, fetch, tmo, perf);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0;
    @(posedge clk);
    #1;

    // Reset held, valid high: bubbles, no fetch.
    step("rst1", 1, 1, 0, 0, 0, S_ZERO, 0, 0);
    step("rst2", 1, 1, 0, 0, 0, S_ZERO, 0, 0);
    step("rst3", 1, 1, 0, 0, 0, S_ZERO, 0, 0);
    chk("perf_rst", perf, 32'd0);

    // Release: one post-release bubble with fetch, then continuous loads.
    step("rel",  0, 1, 0, 0, 0, S_ZERO, 1, 0);
    step("ld1",  0, 1, 0, 0, 0, S_LOAD, 1, 0);
    step("ld2",  0, 1, 0, 0, 0, S_LOAD, 1, 0);
    step("ld3",  0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Short miss: four bubbles then load, no timeout.
    step("bub1", 0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("bub2", 0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("bub3", 0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("bub4", 0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("mret", 0, 1, 0, 0, 0, S_LOAD, 1, 0);
    step("mld",  0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Long miss with MISS_LIMIT=4: pulse on 4th MISS cycle only.
    step("t_run", 0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("t_m1",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("t_m2",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("t_m3",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("t_m4",  0, 0, 0, 0, 0, S_ZERO, 1, 1);
    step("t_m5",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("t_m6",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("t_ret", 0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Stall with valid: hold twice, then load; fetch stays up.
    step("st1",   0, 1, 1, 0, 0, S_HOLD, 1, 0);
    step("st2",   0, 1, 1, 0, 0, S_HOLD, 1, 0);
    step("st_ld", 0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Stalled miss keeps counting; timeout fires while stalled.
    step("sm_run", 0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("sm1",    0, 0, 1, 0, 0, S_HOLD, 1, 0);
    step("sm2",    0, 1, 1, 0, 0, S_HOLD, 1, 0);
    step("sm3",    0, 0, 1, 0, 0, S_HOLD, 1, 0);
    step("sm4",    0, 0, 1, 0, 0, S_HOLD, 1, 1);
    step("sm_ld",  0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Flush with valid: word refused, single FLUSH cycle, then load.
    step("fv",    0, 1, 0, 1, 0, S_ZERO, 1, 0);
    step("fv_fl", 0, 1, 0, 0, 0, S_ZERO, 1, 0);
    step("fv_ld", 0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Flush reasserted while in FLUSH keeps the state.
    step("ff1",   0, 0, 0, 1, 0, S_ZERO, 1, 0);
    step("ff2",   0, 1, 0, 1, 0, S_ZERO, 1, 0);
    step("ff3",   0, 1, 0, 0, 0, S_ZERO, 1, 0);
    step("ff_ld", 0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Halt for 3 cycles with a flush pulse in the 2nd.
    step("h1", 0, 1, 0, 0, 1, S_HOLD, 1, 0);
    step("h2", 0, 1, 0, 1, 1, S_ZERO, 0, 0);
    step("h3", 0, 1, 0, 0, 1, S_ZERO, 1, 0);
    step("h4", 0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Halt release: RUN rules select in the HALT cycle, fetch still low.
    step("hr1", 0, 0, 0, 0, 1, S_HOLD, 1, 0);
    step("hr2", 0, 0, 0, 0, 1, S_HOLD, 0, 0);
    step("hr3", 0, 1, 0, 0, 0, S_LOAD, 0, 0);
    step("hr4", 0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Reset mid-HALT.
    step("rh1", 0, 1, 0, 0, 1, S_HOLD, 1, 0);
    step("rh2", 1, 1, 0, 0, 1, S_ZERO, 0, 0);
    step("rh3", 0, 1, 0, 0, 0, S_ZERO, 1, 0);
    step("rh4", 0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Reset mid-MISS on the would-be timeout cycle: suppressed, counter cleared.
    step("rm_run", 0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm1",    0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm2",    0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm3",    0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm_rst", 1, 0, 0, 0, 0, S_ZERO, 0, 0);
    step("rm_rel", 0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm_b",   0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm_m1",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm_m2",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm_m3",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("rm_m4",  0, 0, 0, 0, 0, S_ZERO, 1, 1);
    step("rm_ld",  0, 1, 0, 0, 0, S_LOAD, 1, 0);

    // Ten-cycle window with three loads.
    perf_before = perf;
    step("p1",  0, 1, 0, 0, 0, S_LOAD, 1, 0);
    step("p2",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("p3",  0, 1, 0, 0, 0, S_LOAD, 1, 0);
    step("p4",  0, 1, 1, 0, 0, S_HOLD, 1, 0);
    step("p5",  0, 1, 0, 0, 0, S_LOAD, 1, 0);
    step("p6",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("p7",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("p8",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("p9",  0, 0, 0, 0, 0, S_ZERO, 1, 0);
    step("p10", 0, 0, 0, 0, 0, S_ZERO, 1, 1);
`ifdef PCONT_INSTSEL_PERF_EN
    chk("perf_win", perf - perf_before, 32'd7);
`else
    chk("perf_off", perf, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
